// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared payload layout and control-flag positions for pipeline stage registers
package pipe_pkg;

    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  funct;
        logic [31:0] imm;
        logic [6:0]  opcode;
    } decode_payload_t;

    localparam int PIPE_DATA_W = $bits(decode_payload_t);
    localparam int PIPE_CTRL_W = 10;

    localparam int CTRL_SAVE_TO_REG = 0;
    localparam int CTRL_RD_MEMORY   = 1;
    localparam int CTRL_WR_MEMORY   = 2;
    localparam int CTRL_IS_BRANCH   = 3;
    localparam int CTRL_IS_JUMP     = 4;
    localparam int CTRL_ALU_SRC     = 5;
    localparam int CTRL_MEM_TO_REG  = 6;
    localparam int CTRL_LOAD_IMM    = 7;
    localparam int CTRL_IS_CSR      = 8;
    localparam int CTRL_HALT        = 9;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one valid + data + ctrl holding register with load and clear
module pipe_skid_entry #(
    parameter int DATA_W = 112,
    parameter int CTRL_W = 10
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clearing only drops valid and flags; data is kept so an emptied stage still shows its last payload.
    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready pipeline stage register with flush and optional skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              stg_clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              in_fire;
    logic              main_load;
    logic              main_clr;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clr;
    logic [DATA_W-1:0] main_d;
    logic [CTRL_W-1:0] main_c;

    assign in_fire = in_valid & in_ready;

    always_comb begin
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (skid_valid) begin
            if (out_ready) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end
        end else if (main_valid) begin
            if (out_ready) begin
                if (in_fire) begin
                    main_load = 1'b1;
                end else begin
                    main_clr = 1'b1;
                end
            end else if (in_fire) begin
                skid_load = 1'b1;
            end
        end else if (in_fire) begin
            main_load = 1'b1;
        end
    end

    assign main_d = main_from_skid ? skid_data : in_data;
    assign main_c = main_from_skid ? skid_ctrl : in_ctrl;

    pipe_skid_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .stg_clk   (stg_clk),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clr),
        .load_data (main_d),
        .load_ctrl (main_c),
        .valid     (main_valid),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    generate
        if (SKID == 1) begin : g_skid
            logic in_ready_q;
            logic skid_valid_nxt;

            pipe_skid_entry #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .stg_clk   (stg_clk),
                .reset     (reset),
                .load      (skid_load),
                .clear     (skid_clr),
                .load_data (in_data),
                .load_ctrl (in_ctrl),
                .valid     (skid_valid),
                .data      (skid_data),
                .ctrl      (skid_ctrl)
            );

            // in_ready is its own flop so out_ready never reaches it combinationally.
            assign skid_valid_nxt = !flush & ((skid_valid & !out_ready) | skid_load);

            always_ff @(posedge stg_clk or posedge reset) begin
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= !skid_valid_nxt;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign in_ready   = !main_valid | out_ready;
        end
    endgenerate

    // A beat leaving through out_ready in the flush cycle was consumed, not dropped.
    logic [1:0]     drop_inc;
    logic [CNT_W:0] drop_sum;

    assign drop_inc = {1'b0, main_valid & !out_ready} + {1'b0, skid_valid} + {1'b0, in_fire};
    assign drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, drop_inc};

    always_ff @(posedge stg_clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

endmodule
